bram_1p_ctrl: RTL and testbench
===============================

Name: bram_1p_ctrl

Overview:
- Request/response initiator that drives the control pins of a single-port BRAM with an output register: en, we, reg_en, addr, data.
- Converts a valid/ready request stream (read or write) into the BRAM's enable sequence.
- Returns read data on a valid/ready response channel.
- Sits between a user master (CPU/DMA/test sequencer) and a bram_1p_out_reg instance; the integrator ties the BRAM reset.

Parameters:
- RAM_WIDTH, 16, data width in bits.
- RAM_ADDR_BITS, 3, address width; depth = 2**RAM_ADDR_BITS.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset (0 = reset).
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  RAM_ADDR_BITS  request address.
- req_wdata_i  in  RAM_WIDTH  write data.
- rsp_valid_o  out  1  read data valid.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_data_o  out  RAM_WIDTH  read data.
- bram_en_o  out  1  to BRAM en_i.
- bram_we_o  out  1  to BRAM we_i.
- bram_reg_en_o  out  1  to BRAM reg_en_i.
- bram_addr_o  out  RAM_ADDR_BITS  to BRAM addr_i.
- bram_wdata_o  out  RAM_WIDTH  to BRAM data_i.
- bram_rdata_i  in  RAM_WIDTH  from BRAM data_o.

Behaviour:
- FSM states: IDLE, WR, RD_ARR, RD_REG, RSP. All BRAM-side outputs are registered.
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - req_ready_o=1 after reset release; held 0 while in reset.
  - rsp_valid_o=0, rsp_data_o=0.
  - bram_en_o, bram_we_o, bram_reg_en_o = 0; bram_addr_o=0; bram_wdata_o=0.
  - Any in-flight transaction is dropped; no response is produced for it.
- req_ready_o = 1 only in IDLE. A request is accepted on the rising edge where req_valid_i && req_ready_o. Address and data are latched at acceptance.
- Write, accepted at edge N:
  - Cycle N..N+1 (state WR): bram_en_o=1, bram_we_o=1, addr/wdata = latched values. BRAM writes at edge N+1.
  - Edge N+1: return to IDLE; all enables drop to 0. Write throughput is 1 per 2 cycles.
  - No response is generated for writes.
- Read, accepted at edge N:
  - State RD_ARR: bram_en_o=1, bram_we_o=0, addr latched. Array output is valid after edge N+1.
  - State RD_REG: bram_en_o=0, bram_reg_en_o=1. BRAM output register loads at edge N+2.
  - State RSP, entered at edge N+2: bram_reg_en_o=0.
  - Edge N+3: rsp_data_o captured from bram_rdata_i; rsp_valid_o=1.
  - Total read latency: accept edge to rsp_valid_o high = 3 clocks.
- RSP handshake:
  - rsp_valid_o and rsp_data_o hold stable until rsp_valid_o && rsp_ready_i at an edge.
  - At that edge: rsp_valid_o=0, state=IDLE, req_ready_o=1 the next cycle.
  - If rsp_ready_i is already 1 when rsp_valid_o rises, the response completes at the next edge.
- Back-to-back: no new request is accepted while a write, read, or pending response is outstanding (req_ready_o=0). req_valid_i held high is serviced immediately on return to IDLE.
- Address range: full 0..2**RAM_ADDR_BITS-1; no wrap logic is required beyond natural width.
- Unused outputs in a given state: bram_wdata_o/bram_addr_o keep their last value; only the enables carry meaning.

Optional Feature:
- Macro: BRAM_1P_CTRL_STAT_EN.
- Defined: adds ports wr_cnt_o (out, 16) and rd_cnt_o (out, 16).
  - Counters reset to 0.
  - wr_cnt_o increments on each accepted write; rd_cnt_o increments on each completed read response handshake.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_i=0 mid-read (state RD_REG) -> all BRAM enables 0 and rsp_valid_o=0 immediately; after release req_ready_o=1 and no response appears.
- Fill: write addr 0..7 with data 16'h1000+addr, req_valid_i held high -> bram_en_o/bram_we_o pulse 1 cycle per write, req_ready_o toggles 1/0, 8 writes in 16 cycles.
- Read latency: read addr 5 after fill, rsp_ready_i=1 -> rsp_valid_o high exactly 3 clocks after acceptance, rsp_data_o=16'h1005; bram_en_o then bram_reg_en_o each high 1 cycle.
- Backpressure: read addr 2, rsp_ready_i=0 for 10 cycles -> rsp_valid_o=1 and rsp_data_o=16'h1002 stable, req_ready_o=0 throughout; completes one edge after rsp_ready_i=1.
- Overwrite: write addr 3 = 16'hBEEF, then read addr 3 -> rsp_data_o=16'hBEEF; with BRAM_1P_CTRL_STAT_EN, wr_cnt_o=9 and rd_cnt_o increments by 1 per completed read.

Source files
------------

// File: rtl/bram_1p_ctrl.sv
// bram_1p_ctrl: valid/ready read/write initiator for a 1-port BRAM with output reg.
// Ports: clk_i, rst_i (async, low), req_* in, rsp_* out, bram_* pins; BRAM_1P_CTRL_STAT_EN adds wr/rd counters.
module bram_1p_ctrl #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [RAM_ADDR_BITS-1:0] req_addr_i,
  input  logic [RAM_WIDTH-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [RAM_WIDTH-1:0]     rsp_data_o,
  output logic                     bram_en_o,
  output logic                     bram_we_o,
  output logic                     bram_reg_en_o,
  output logic [RAM_ADDR_BITS-1:0] bram_addr_o,
  output logic [RAM_WIDTH-1:0]     bram_wdata_o,
  input  logic [RAM_WIDTH-1:0]     bram_rdata_i
`ifdef BRAM_1P_CTRL_STAT_EN
  ,
  output logic [15:0]              wr_cnt_o,
  output logic [15:0]              rd_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ARR,
    RD_REG,
    RSP
  } state_e;

  state_e                   state_q;
  logic                     en_q;
  logic                     we_q;
  logic                     reg_en_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_WIDTH-1:0]     wdata_q;
  logic                     rsp_valid_q;
  logic [RAM_WIDTH-1:0]     rsp_data_q;

  // Gated by rst_i so ready stays low while reset is held.
  assign req_ready_o   = rst_i && (state_q == IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign bram_en_o     = en_q;
  assign bram_we_o     = we_q;
  assign bram_reg_en_o = reg_en_q;
  assign bram_addr_o   = addr_q;
  assign bram_wdata_o  = wdata_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      reg_en_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            en_q    <= 1'b1;
            we_q    <= req_we_i;
            state_q <= req_we_i ? WR : RD_ARR;
          end
        end
        WR: begin
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
        RD_ARR: begin
          en_q     <= 1'b0;
          reg_en_q <= 1'b1;
          state_q  <= RD_REG;
        end
        RD_REG: begin
          reg_en_q <= 1'b0;
          state_q  <= RSP;
        end
        RSP: begin
          // First RSP cycle captures the output register; then wait for handshake.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bram_rdata_i;
          end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef BRAM_1P_CTRL_STAT_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] rd_cnt_q;

  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && req_valid_i && req_we_i
          && wr_cnt_q != 16'hFFFF)
        wr_cnt_q <= wr_cnt_q + 16'd1;
      if (state_q == RSP && rsp_valid_q && rsp_ready_i
          && rd_cnt_q != 16'hFFFF)
        rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_1p_ctrl.sv
// tb_bram_1p_ctrl: directed bench with a transaction-level model of bram_1p_ctrl
// and a behavioural single-port BRAM with output register.
module tb_bram_1p_ctrl;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [W-1:0]  req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [W-1:0]  rsp_data_o;
  logic          bram_en_o;
  logic          bram_we_o;
  logic          bram_reg_en_o;
  logic [AW-1:0] bram_addr_o;
  logic [W-1:0]  bram_wdata_o;
  logic [W-1:0]  bram_rdata_i;
`ifdef BRAM_1P_CTRL_STAT_EN
  logic [15:0]   wr_cnt_o;
  logic [15:0]   rd_cnt_o;
`endif

  bram_1p_ctrl #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_we_i      (req_we_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .bram_en_o     (bram_en_o),
    .bram_we_o     (bram_we_o),
    .bram_reg_en_o (bram_reg_en_o),
    .bram_addr_o   (bram_addr_o),
    .bram_wdata_o  (bram_wdata_o),
    .bram_rdata_i  (bram_rdata_i)
`ifdef BRAM_1P_CTRL_STAT_EN
    ,
    .wr_cnt_o      (wr_cnt_o),
    .rd_cnt_o      (rd_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural BRAM: array read on en, output register on reg_en.
  logic [W-1:0] mem [8];
  logic [W-1:0] arr_q;
  logic [W-1:0] out_q;
  always @(posedge clk) begin
    if (bram_en_o) begin
      if (bram_we_o) mem[bram_addr_o] <= bram_wdata_o;
      else           arr_q <= mem[bram_addr_o];
    end
    if (bram_reg_en_o) out_q <= arr_q;
  end
  assign bram_rdata_i = out_q;

  // Transaction model: age counts edges since acceptance.
  logic          m_busy;
  logic          m_wr;
  int            m_age;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata;
  logic          m_rsp_valid;
  logic [W-1:0]  m_rsp_data;
  logic [W-1:0]  m_mem [8];
`ifdef BRAM_1P_CTRL_STAT_EN
  int            m_wcnt;
  int            m_rcnt;
`endif

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_busy      <= 1'b0;
      m_wr        <= 1'b0;
      m_age       <= 0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_rsp_valid <= 1'b0;
      m_rsp_data  <= '0;
`ifdef BRAM_1P_CTRL_STAT_EN
      m_wcnt      <= 0;
      m_rcnt      <= 0;
`endif
    end else if (!m_busy) begin
      if (req_valid_i) begin
        m_busy  <= 1'b1;
        m_age   <= 0;
        m_wr    <= req_we_i;
        m_addr  <= req_addr_i;
        m_wdata <= req_wdata_i;
        if (req_we_i) begin
          m_mem[req_addr_i] <= req_wdata_i;
`ifdef BRAM_1P_CTRL_STAT_EN
          if (m_wcnt < 65535) m_wcnt <= m_wcnt + 1;
`endif
        end
      end
    end else if (m_wr) begin
      m_busy <= 1'b0;
    end else if (m_rsp_valid) begin
      if (rsp_ready_i) begin
        m_rsp_valid <= 1'b0;
        m_busy      <= 1'b0;
`ifdef BRAM_1P_CTRL_STAT_EN
        if (m_rcnt < 65535) m_rcnt <= m_rcnt + 1;
`endif
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age == 2) begin
        m_rsp_valid <= 1'b1;
        m_rsp_data  <= m_mem[m_addr];
      end
    end
  end

  always @(negedge clk) begin
    logic e_en, e_we, e_reg;
    e_en  = m_busy && m_age == 0;
    e_we  = m_busy && m_wr && m_age == 0;
    e_reg = m_busy && !m_wr && m_age == 1;
    chk("ready", 32'(req_ready_o), 32'(rst_i && !m_busy));
    chk("en", 32'(bram_en_o), 32'(e_en));
    chk("we", 32'(bram_we_o), 32'(e_we));
    chk("reg_en", 32'(bram_reg_en_o), 32'(e_reg));
    chk("rsp_valid", 32'(rsp_valid_o), 32'(m_rsp_valid));
    if (e_en || e_reg) chk("addr", 32'(bram_addr_o), 32'(m_addr));
    if (e_we) chk("wdata", 32'(bram_wdata_o), 32'(m_wdata));
    if (m_rsp_valid) chk("rsp_data", 32'(rsp_data_o), 32'(m_rsp_data));
`ifdef BRAM_1P_CTRL_STAT_EN
    chk("wr_cnt", 32'(wr_cnt_o), 32'(m_wcnt));
    chk("rd_cnt", 32'(rd_cnt_o), 32'(m_rcnt));
`endif
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a,
                        input logic [W-1:0] d, output int acc);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    wait_ready();
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid_o && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [W-1:0] exp);
    int acc;
    rsp_ready_i = 1'b1;
    do_req(1'b0, a, '0, acc);
    req_valid_i = 1'b0;
    wait_rsp();
    chk("rd_latency", 32'(cyc - acc), 32'd3);
    chk("rd_data", 32'(rsp_data_o), 32'(exp));
    @(posedge clk);
    #1;
    chk("rd_done", 32'(rsp_valid_o), 32'd0);
    chk("rd_ready_back", 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int acc, prev, first;
    #3;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_en", 32'(bram_en_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    chk("rst_addr", 32'(bram_addr_o), 32'd0);
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready_o), 32'd1);

    // Fill with valid held high: one write every 2 cycles.
    prev  = 0;
    first = 0;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, 3'(i), 16'h1000 + 16'(i), acc);
      if (i == 0) first = acc;
      else chk("fill_gap", 32'(acc - prev), 32'd2);
      prev = acc;
    end
    req_valid_i = 1'b0;
    chk("fill_span", 32'(prev - first), 32'd14);
    @(negedge clk);
    #1;

    rd_chk(3'd5, 16'h1005);
    rd_chk(3'd0, 16'h1000);

    // Backpressure on the response channel.
    rsp_ready_i = 1'b0;
    do_req(1'b0, 3'd2, '0, acc);
    req_valid_i = 1'b0;
    wait_rsp();
    chk("bp_latency", 32'(cyc - acc), 32'd3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data", 32'(rsp_data_o), 32'h1002);
      chk("bp_ready", 32'(req_ready_o), 32'd0);
    end
    #1;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done", 32'(rsp_valid_o), 32'd0);
    chk("bp_ready_back", 32'(req_ready_o), 32'd1);

    // Overwrite then read back.
    do_req(1'b1, 3'd3, 16'hBEEF, acc);
    req_valid_i = 1'b0;
    @(negedge clk);
    #1;
    rd_chk(3'd3, 16'hBEEF);
    rd_chk(3'd7, 16'h1007);
`ifdef BRAM_1P_CTRL_STAT_EN
    chk("stat_wr", 32'(wr_cnt_o), 32'd9);
    chk("stat_rd", 32'(rd_cnt_o), 32'd5);
`endif

    // Reset asserted while the output register is loading.
    rsp_ready_i = 1'b1;
    do_req(1'b0, 3'd1, '0, acc);
    req_valid_i = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_reg_en", 32'(bram_reg_en_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_en", 32'(bram_en_o), 32'd0);
    chk("mid_we", 32'(bram_we_o), 32'd0);
    chk("mid_reg_en_clr", 32'(bram_reg_en_o), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(req_ready_o), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", 32'(rsp_valid_o), 32'd0);
    end
`ifdef BRAM_1P_CTRL_STAT_EN
    chk("mid_stat_wr", 32'(wr_cnt_o), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
